// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl -- pipeline hazard controller for a classic 5-stage core.
//
// Generates PC / pipeline-register hold and bubble-insert controls from
// load-use hazards, taken branches and data-memory back-pressure. It also
// flags a stuck memory and keeps saturating performance counters.
//
// Parameters
//   LOAD_STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   MEM_TIMEOUT        consecutive mem_busy cycles that raise mem_timeout
//                      (1..65535)
//
// Ports
//   clk, rstn                  clock (rising edge) / async active-low reset
//   id_rs1, id_rs2             source registers of the instruction in ID
//   id_uses_rs1, id_uses_rs2   qualifiers for id_rs1 / id_rs2
//   ex_rd, ex_mem_read         destination of the EX instruction; EX is a load
//   branch_taken               taken branch/jump resolved in EX this cycle
//   mem_busy                   data memory not ready this cycle
//   pc_stall, ifid_stall,
//   idex_stall, exmem_stall    hold controls
//   ifid_flush, idex_flush     bubble-insert controls
//   mem_timeout                sticky stuck-memory flag
//   stall_cycles, flush_count  saturating counters of pc_stall / ifid_flush
// ---------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        exmem_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        mem_timeout,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  typedef enum logic [1:0] {
    RUN,
    LOAD_STALL,
    MEM_WAIT
  } state_e;

  localparam logic [2:0]  BUB_INIT = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [15:0] WAIT_LIM = 16'(MEM_TIMEOUT);
  localparam logic [15:0] WAIT_HIT = 16'(MEM_TIMEOUT - 1);

  state_e      state_q, state_d;
  state_e      ret_q, ret_d;       // state to resume once memory is ready
  state_e      eff_state;
  logic [2:0]  bub_q, bub_d;       // bubbles still owed after the current one
  logic [15:0] wait_q, wait_d;     // consecutive mem_busy cycles, saturating
  logic        to_q, to_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic timeout_hit;
  logic pc_stall_c, ifid_stall_c, idex_stall_c, exmem_stall_c;
  logic ifid_flush_c, idex_flush_c;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                     (id_uses_rs2 && (id_rs2 == ex_rd)));

  // Leaving MEM_WAIT is evaluated as if already back in the saved state,
  // so the resumed state's actions happen on the very cycle memory frees.
  assign eff_state = (state_q == MEM_WAIT) ? ret_q : state_q;

  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    bub_d         = bub_q;
    pc_stall_c    = 1'b0;
    ifid_stall_c  = 1'b0;
    idex_stall_c  = 1'b0;
    exmem_stall_c = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;

    if (mem_busy) begin
      // Whole pipe frozen; the bubble counter is left untouched.
      pc_stall_c    = 1'b1;
      ifid_stall_c  = 1'b1;
      idex_stall_c  = 1'b1;
      exmem_stall_c = 1'b1;
      state_d       = MEM_WAIT;
      if (state_q != MEM_WAIT) begin
        ret_d = state_q;
      end
    end else if (branch_taken) begin
      ifid_flush_c = 1'b1;
      idex_flush_c = 1'b1;
      bub_d        = '0;
      state_d      = RUN;
    end else if (eff_state == LOAD_STALL) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
      bub_d        = bub_q - 3'd1;
      state_d      = (bub_q == 3'd1) ? RUN : LOAD_STALL;
    end else if (load_use) begin
      pc_stall_c   = 1'b1;
      ifid_stall_c = 1'b1;
      idex_flush_c = 1'b1;
      bub_d        = BUB_INIT;
      state_d      = (BUB_INIT != 3'd0) ? LOAD_STALL : RUN;
    end else begin
      state_d = RUN;
    end
  end

  // The flag is visible during the cycle that completes the timeout window.
  assign timeout_hit = mem_busy && (wait_q >= WAIT_HIT);

  always_comb begin
    wait_d = '0;
    if (mem_busy) begin
      wait_d = (wait_q == WAIT_LIM) ? wait_q : wait_q + 16'd1;
    end
    to_d        = to_q | timeout_hit;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (ifid_flush_c && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= RUN;
      ret_q       <= RUN;
      bub_q       <= '0;
      wait_q      <= '0;
      to_q        <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      bub_q       <= bub_d;
      wait_q      <= wait_d;
      to_q        <= to_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs are combinational from inputs, so reset must mask them too.
  assign pc_stall     = rstn & pc_stall_c;
  assign ifid_stall   = rstn & ifid_stall_c;
  assign idex_stall   = rstn & idex_stall_c;
  assign exmem_stall  = rstn & exmem_stall_c;
  assign ifid_flush   = rstn & ifid_flush_c;
  assign idex_flush   = rstn & idex_flush_c;
  assign mem_timeout  = rstn & (to_q | timeout_hit);
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl -- self-checking bench for hazard_ctrl.
// Two instances share all inputs: u0 with defaults (1 bubble, timeout 255)
// and u1 with 3 bubbles and timeout 8.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs1, id_uses_rs2, ex_mem_read, branch_taken, mem_busy;

  logic        pc0, ifs0, ids0, exs0, iff0, idf0, to0;
  logic        pc1, ifs1, ids1, exs1, iff1, idf1, to1;
  logic [31:0] sc0, fc0, sc1, fc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .MEM_TIMEOUT(255)) u0 (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc0), .ifid_stall(ifs0), .idex_stall(ids0), .exmem_stall(exs0),
    .ifid_flush(iff0), .idex_flush(idf0), .mem_timeout(to0),
    .stall_cycles(sc0), .flush_count(fc0)
  );

  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .MEM_TIMEOUT(8)) u1 (
    .clk(clk), .rstn(rstn),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .branch_taken(branch_taken), .mem_busy(mem_busy),
    .pc_stall(pc1), .ifid_stall(ifs1), .idex_stall(ids1), .exmem_stall(exs1),
    .ifid_flush(iff1), .idex_flush(idf1), .mem_timeout(to1),
    .stall_cycles(sc1), .flush_count(fc1)
  );

  // {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, mem_timeout}
  logic [6:0]  out_w [2];
  logic [31:0] sc_w  [2];
  logic [31:0] fc_w  [2];
  assign out_w[0] = {pc0, ifs0, ids0, exs0, iff0, idf0, to0};
  assign out_w[1] = {pc1, ifs1, ids1, exs1, iff1, idf1, to1};
  assign sc_w[0]  = sc0;
  assign sc_w[1]  = sc1;
  assign fc_w[0]  = fc0;
  assign fc_w[1]  = fc1;

  localparam logic [6:0] BUBBLE = 7'b1100010;
  localparam logic [6:0] FREEZE = 7'b1111000;
  localparam logic [6:0] BFLUSH = 7'b0000110;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: bubbles owed, consecutive busy cycles, sticky flag and
  // counters, advanced once per cycle from the rules of the block.
  int     n_bub [2] = '{1, 3};
  int     t_lim [2] = '{255, 8};
  int     rem   [2];
  int     run   [2];
  bit     stick [2];
  longint m_sc  [2];
  longint m_fc  [2];

  always @(negedge clk) begin
    logic [6:0] e;
    logic       lu;
    for (int i = 0; i < 2; i++) begin
      e = '0;
      if (!rstn) begin
        rem[i] = 0; run[i] = 0; stick[i] = 1'b0; m_sc[i] = 0; m_fc[i] = 0;
        chk($sformatf("m%0d_rst_out", i), 32'(out_w[i]), 32'd0);
        chk($sformatf("m%0d_rst_sc", i), sc_w[i], 32'd0);
        chk($sformatf("m%0d_rst_fc", i), fc_w[i], 32'd0);
      end else begin
        chk($sformatf("m%0d_sc", i), sc_w[i], m_sc[i][31:0]);
        chk($sformatf("m%0d_fc", i), fc_w[i], m_fc[i][31:0]);
        lu = ex_mem_read && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
        if (mem_busy) begin
          e[6:3] = 4'b1111;
        end else if (branch_taken) begin
          e[2:1] = 2'b11;
          rem[i] = 0;
        end else if (rem[i] > 0) begin
          e = BUBBLE;
          rem[i] = rem[i] - 1;
        end else if (lu) begin
          e = BUBBLE;
          rem[i] = n_bub[i] - 1;
        end
        e[0] = stick[i] || (mem_busy && (run[i] + 1 >= t_lim[i]));
        chk($sformatf("m%0d_out", i), 32'(out_w[i]), 32'(e));
        if (e[0]) stick[i] = 1'b1;
        run[i] = mem_busy ? run[i] + 1 : 0;
        if (e[6] && m_sc[i] < 64'hFFFF_FFFF) m_sc[i] = m_sc[i] + 1;
        if (e[2] && m_fc[i] < 64'hFFFF_FFFF) m_fc[i] = m_fc[i] + 1;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
    ex_rd = 5'd0; ex_mem_read = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
  endtask

  task automatic hazard(input logic [4:0] rd);
    ex_mem_read = 1'b1; ex_rd = rd; id_rs2 = rd; id_uses_rs2 = 1'b1;
  endtask

  task automatic do_reset;
    idle();
    rstn = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  // {rs1, rs2, uses_rs1, uses_rs2, rd, mem_read}
  logic [17:0] vec [6] = '{
    {5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1},   // rs1 hazard
    {5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1},   // rs1 match but unused
    {5'd3, 5'd4, 1'b1, 1'b1, 5'd9, 1'b1},   // no match
    {5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0},   // match but not a load
    {5'd1, 5'd31, 1'b1, 1'b1, 5'd31, 1'b1}, // rs2 hazard on x31
    {5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1}    // x0 never hazards
  };

  initial begin
    int cnt;
    logic [17:0] v;
    idle();
    rstn = 1'b0;
    mem_busy = 1'b1;               // outputs must stay low under reset
    @(negedge clk);
    chk("rst_out0", 32'(out_w[0]), 32'd0);
    chk("rst_out1", 32'(out_w[1]), 32'd0);
    tick();
    mem_busy = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // Single load-use, default one bubble; u1 gives three.
    hazard(5'd5);
    @(negedge clk);
    chk("lu1_bubble", 32'(out_w[0]), 32'(BUBBLE));
    cnt = int'(pc1);
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) chk("lu1_release", 32'(out_w[0]), 32'd0);
      cnt += int'(pc1);
      tick();
    end
    chk("lu3_bubbles", cnt, 3);
    chk("lu1_stall_cycles", sc0, 32'd1);
    chk("lu3_stall_cycles", sc1, 32'd3);

    // Same hazard against x0.
    hazard(5'd0);
    @(negedge clk);
    chk("x0_no_stall0", 32'(out_w[0]), 32'd0);
    chk("x0_no_stall1", 32'(out_w[1]), 32'd0);
    tick();
    idle();

    foreach (vec[j]) begin
      v = vec[j];
      id_rs1 = v[17:13]; id_rs2 = v[12:8]; id_uses_rs1 = v[7]; id_uses_rs2 = v[6];
      ex_rd = v[5:1]; ex_mem_read = v[0];
      tick();
      idle();
      repeat (3) tick();
    end

    // Branch wins over a concurrent load-use.
    do_reset();
    hazard(5'd5);
    branch_taken = 1'b1;
    @(negedge clk);
    chk("br_lu_out0", 32'(out_w[0]), 32'(BFLUSH));
    chk("br_lu_out1", 32'(out_w[1]), 32'(BFLUSH));
    tick();
    idle();
    @(negedge clk);
    chk("br_flush_count", fc0, 32'd1);
    tick();

    // Branch aborts a LOAD_STALL in progress.
    hazard(5'd5);
    tick();
    idle();
    branch_taken = 1'b1;
    @(negedge clk);
    chk("br_abort_flush", 32'(out_w[1]), 32'(BFLUSH));
    tick();
    branch_taken = 1'b0;
    @(negedge clk);
    chk("br_abort_idle", 32'(out_w[1]), 32'd0);
    tick();

    // mem_busy for 4 cycles in the middle of a 3-bubble stall.
    do_reset();
    hazard(5'd5);
    @(negedge clk);
    chk("mw_bub1", 32'(out_w[1]), 32'(BUBBLE));
    tick();
    idle();
    @(negedge clk);
    chk("mw_bub2", 32'(out_w[1]), 32'(BUBBLE));
    tick();
    mem_busy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("mw_freeze%0d", k), 32'(out_w[1]), 32'(FREEZE));
      tick();
    end
    mem_busy = 1'b0;
    @(negedge clk);
    chk("mw_bub3", 32'(out_w[1]), 32'(BUBBLE));
    tick();
    @(negedge clk);
    chk("mw_done", 32'(out_w[1]), 32'd0);
    chk("mw_stall_cycles", sc1, 32'd7);
    tick();

    // Timeout on the 8th busy cycle, sticky afterwards, cleared by reset.
    do_reset();
    mem_busy = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("to_busy%0d", k), 32'(to1), (k >= 8) ? 32'd1 : 32'd0);
      tick();
    end
    mem_busy = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("to_sticky", 32'(to1), 32'd1);
      tick();
    end
    mem_busy = 1'b1;
    tick();
    rstn = 1'b0;
    #1;
    chk("rst_mw_out0", 32'(out_w[0]), 32'd0);
    chk("rst_mw_out1", 32'(out_w[1]), 32'd0);
    tick();
    mem_busy = 1'b0;
    rstn = 1'b1;
    #1;
    chk("rel_sc1", sc1, 32'd0);
    chk("rel_fc1", fc1, 32'd0);
    chk("rel_to1", 32'(to1), 32'd0);
    hazard(5'd5);
    @(negedge clk);
    chk("rel_run_lu", 32'(out_w[1]), 32'(BUBBLE));
    tick();
    idle();
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter LOAD_STALL_CYCLES, default 1, meaning bubble cycles inserted per load-use hazard (legal 1..7).
REQ-002 The block SHALL have parameter MEM_TIMEOUT, default 255, meaning maximum consecutive mem_busy cycles before an error is flagged (legal 1..65535).
REQ-003 The block SHALL have the port clk, input, width 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rstn, input, width 1, the asynchronous active-low reset.
REQ-005 The block SHALL have the ports id_rs1 and id_rs2, inputs, width 5 each, the source registers of the instruction in ID.
REQ-006 The block SHALL have the ports id_uses_rs1 and id_uses_rs2, inputs, width 1 each, qualifying id_rs1 and id_rs2.
REQ-007 The block SHALL have the ports ex_rd (input, width 5) and ex_mem_read (input, width 1), the destination register of the instruction in EX and a flag that it is a load.
REQ-008 The block SHALL have the port branch_taken, input, width 1, a taken branch/jump resolved in EX this cycle.
REQ-009 The block SHALL have the port mem_busy, input, width 1, data memory not ready this cycle.
REQ-010 The block SHALL have the ports pc_stall, ifid_stall, idex_stall and exmem_stall, outputs, width 1 each, hold controls for the PC and the pipeline registers.
REQ-011 The block SHALL have the ports ifid_flush and idex_flush, outputs, width 1 each, bubble-insert controls.
REQ-012 The block SHALL have the port mem_timeout, output, width 1, a sticky error flag.
REQ-013 The block SHALL have the ports stall_cycles and flush_count, outputs, width 32 each, saturating performance counters.

Function
REQ-014 The FSM SHALL have states RUN, LOAD_STALL and MEM_WAIT, and all control outputs SHALL be combinational from the state and the current inputs.
REQ-015 Priority SHALL be mem_busy first, then branch_taken, then load-use.
REQ-016 Load-use SHALL be defined as ex_mem_read=1, ex_rd!=0, and ((id_uses_rs1 and id_rs1==ex_rd) or (id_uses_rs2 and id_rs2==ex_rd)).
REQ-017 Whenever mem_busy=1 (any state), the block SHALL:
- assert pc_stall, ifid_stall, idex_stall and exmem_stall;
- keep both flushes at 0;
- enter or stay in MEM_WAIT.
REQ-018 In MEM_WAIT with mem_busy=0, the block SHALL return to the state held before entry and evaluate the other conditions normally that same cycle.
REQ-019 The wait counter SHALL:
- increment each mem_busy cycle and clear when mem_busy=0;
- set mem_timeout when it reaches MEM_TIMEOUT;
- leave mem_timeout set until reset.
REQ-020 On branch_taken=1 with mem_busy=0, the block SHALL assert ifid_flush and idex_flush, hold all stalls at 0, go to RUN, and abort any LOAD_STALL.
REQ-021 In RUN, load-use with no higher-priority event SHALL:
- assert pc_stall, ifid_stall and idex_flush;
- load the bubble counter with LOAD_STALL_CYCLES-1;
- go to LOAD_STALL if that value is non-zero, else stay in RUN.
REQ-022 In LOAD_STALL, the block SHALL:
- assert pc_stall, ifid_stall and idex_flush;
- decrement the counter each cycle;
- return to RUN on the cycle the counter reaches 0, outputs deasserting the following cycle;
- not re-detect load-use while in this state.
REQ-023 stall_cycles SHALL increment on every cycle in which pc_stall=1.
REQ-024 flush_count SHALL increment on every cycle in which ifid_flush=1.
REQ-025 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-026 A mem_busy occurring during LOAD_STALL SHALL freeze the bubble counter and resume it afterward.

Reset
REQ-027 While rstn=0, the block SHALL hold state=RUN, all internal counters=0, mem_timeout=0, stall_cycles=0, flush_count=0, and all stall/flush outputs=0, regardless of the other inputs.
REQ-028 Reset asserted mid-LOAD_STALL or mid-MEM_WAIT SHALL abort the operation immediately, and the first cycle after release SHALL be evaluated in RUN.

Verification
REQ-029 The bench SHALL check: ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1, LOAD_STALL_CYCLES=1 -> one cycle of pc_stall=ifid_stall=idex_flush=1, then all 0; stall_cycles=1.
REQ-030 The bench SHALL check: the same hazard with ex_rd=0 -> no stall; the hazard with LOAD_STALL_CYCLES=3 -> exactly 3 bubble cycles.
REQ-031 The bench SHALL check: branch_taken=1 concurrent with a load-use -> ifid_flush=idex_flush=1 and pc_stall=0; flush_count=1.
REQ-032 The bench SHALL check: mem_busy=1 for 4 cycles during LOAD_STALL (3 cycles) -> all four stalls=1 for 4 cycles, with the remaining bubbles completing afterward.
REQ-033 The bench SHALL check: MEM_TIMEOUT=8 with mem_busy held for 10 cycles -> mem_timeout rises on the 8th cycle and stays 1 after mem_busy=0 until rstn=0.
REQ-034 The bench SHALL check: rstn pulsed low during MEM_WAIT -> all outputs 0 immediately, and counters 0 after release.
